// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the triggered ADC snapshot buffer.
package adc_capture_pkg;

   localparam int DEF_IN_WIDTH    = 14;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_ADDR_WIDTH  = 9;
   localparam int DEF_PRE_TRIG    = 128;
   localparam int DEF_DECIM_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      PREFILL,
      ARMED,
      POST,
      READOUT
   } state_t;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module capture_ram
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:depth_of(ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/adc_capture_buffer.sv
// Circular capture with level/slope trigger, frozen pre/post window and valid/ready readout.
// Optional input decimation is built in when ADC_CAPTURE_DECIM_EN is defined.
module adc_capture_buffer
   import adc_capture_pkg::*;
#(
   parameter int IN_WIDTH    = DEF_IN_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int PRE_TRIG    = DEF_PRE_TRIG,
   parameter int DECIM_WIDTH = DEF_DECIM_WIDTH
) (
   input  logic                   clk_adc,
   input  logic                   reset_n,
   input  logic [IN_WIDTH-1:0]    data_in,
   input  logic                   arm,
   input  logic                   force_trig,
   input  logic [DATA_WIDTH-1:0]  trig_level,
   input  logic                   trig_slope,
`ifdef ADC_CAPTURE_DECIM_EN
   input  logic [DECIM_WIDTH-1:0] decim,
`endif
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic                   rd_last,
   output logic                   busy,
   output logic                   triggered
);

   localparam int DEPTH    = depth_of(ADDR_WIDTH);
   localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
   localparam logic [ADDR_WIDTH-1:0] PRE_LAST    = ADDR_WIDTH'(PRE_TRIG - 1);
   localparam logic [ADDR_WIDTH-1:0] POST_LAST   = ADDR_WIDTH'(POST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] PRE_OFS     = ADDR_WIDTH'(PRE_TRIG);
   localparam logic [ADDR_WIDTH:0]   RD_TOTAL    = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   RD_LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

   state_t                 state_reg, state_next;
   logic [ADDR_WIDTH-1:0]  wr_ptr_reg, cnt_reg, trig_addr_reg, rd_addr_reg;
   logic [ADDR_WIDTH:0]    issue_cnt_reg;
   logic [DATA_WIDTH-1:0]  prev_reg;
   logic                   triggered_reg;
   logic                   pend_reg, pend_last_reg;
   logic                   out_valid_reg, out_last_reg;
   logic [DATA_WIDTH-1:0]  out_data_reg;
   logic                   skid_valid_reg, skid_last_reg;
   logic [DATA_WIDTH-1:0]  skid_data_reg;
   logic [DATA_WIDTH-1:0]  ram_q;
   logic [DATA_WIDTH-1:0]  sample;
   logic                   sample_en, wr_en, trig_hit, pop, issue;

   assign sample = data_in[IN_WIDTH-1 -: DATA_WIDTH];

   generate
      if (IN_WIDTH > DATA_WIDTH) begin : g_lsb
         logic unused_lsbs;
         assign unused_lsbs = ^data_in[IN_WIDTH-DATA_WIDTH-1:0];
      end
   endgenerate

`ifdef ADC_CAPTURE_DECIM_EN
   logic [DECIM_WIDTH-1:0] decim_reg, decim_cnt_reg;

   // Ratio is frozen at arm so a mid-capture change cannot skew the window timebase.
   always_ff @(posedge clk_adc or negedge reset_n) begin
      if (!reset_n) begin
         decim_reg     <= '0;
         decim_cnt_reg <= '0;
      end else if (state_reg == IDLE) begin
         if (arm) begin
            decim_reg     <= decim;
            decim_cnt_reg <= '0;
         end
      end else if (decim_cnt_reg == decim_reg) begin
         decim_cnt_reg <= '0;
      end else begin
         decim_cnt_reg <= decim_cnt_reg + 1'b1;
      end
   end

   assign sample_en = (decim_cnt_reg == '0);
`else
   localparam logic [DECIM_WIDTH-1:0] DECIM_NONE = '0;
   assign sample_en = (DECIM_NONE == '0);
`endif

   assign wr_en    = sample_en && (state_reg inside {PREFILL, ARMED, POST});
   assign trig_hit = (state_reg == ARMED) && sample_en &&
                     (force_trig ||
                      (!trig_slope && prev_reg <  trig_level && sample >= trig_level) ||
                      ( trig_slope && prev_reg >= trig_level && sample <  trig_level));
   assign pop      = out_valid_reg && rd_ready;
   // At most two reads in flight or buffered, so the skid slot can never overflow.
   assign issue    = (state_reg == READOUT) && (issue_cnt_reg != RD_TOTAL) &&
                     (pop || (2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(pend_reg) < 2'd2));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (arm) state_next = PREFILL;
         PREFILL: if (sample_en && cnt_reg == PRE_LAST) state_next = ARMED;
         ARMED:   if (trig_hit) state_next = POST;
         POST:    if (sample_en && cnt_reg == POST_LAST) state_next = READOUT;
         READOUT: if (pop && out_last_reg) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_adc or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         cnt_reg       <= '0;
         trig_addr_reg <= '0;
         rd_addr_reg   <= '0;
         issue_cnt_reg <= '0;
         prev_reg      <= '0;
         triggered_reg <= 1'b0;
         pend_reg      <= 1'b0;
         pend_last_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            prev_reg   <= sample;
         end
         case (state_reg)
            IDLE: if (arm) begin
               wr_ptr_reg <= '0;
               cnt_reg    <= '0;
            end
            PREFILL: if (sample_en) cnt_reg <= (cnt_reg == PRE_LAST) ? '0 : cnt_reg + 1'b1;
            ARMED: if (trig_hit) begin
               trig_addr_reg <= wr_ptr_reg;
               triggered_reg <= 1'b1;
               cnt_reg       <= '0;
            end
            POST: if (sample_en) begin
               if (cnt_reg == POST_LAST) begin
                  cnt_reg       <= '0;
                  rd_addr_reg   <= trig_addr_reg - PRE_OFS;
                  issue_cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            READOUT: if (pop && out_last_reg) triggered_reg <= 1'b0;
            default: ;
         endcase
         if (issue) begin
            rd_addr_reg   <= rd_addr_reg + 1'b1;
            issue_cnt_reg <= issue_cnt_reg + 1'b1;
         end
         pend_reg      <= issue;
         pend_last_reg <= issue && (issue_cnt_reg == RD_LAST_IDX);
      end
   end

   always_ff @(posedge clk_adc or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
         out_data_reg   <= '0;
         skid_valid_reg <= 1'b0;
         skid_last_reg  <= 1'b0;
         skid_data_reg  <= '0;
      end else if (!out_valid_reg || rd_ready) begin
         if (skid_valid_reg) begin
            out_valid_reg  <= 1'b1;
            out_data_reg   <= skid_data_reg;
            out_last_reg   <= skid_last_reg;
            skid_valid_reg <= pend_reg;
            skid_data_reg  <= ram_q;
            skid_last_reg  <= pend_last_reg;
         end else begin
            out_valid_reg <= pend_reg;
            out_last_reg  <= pend_reg && pend_last_reg;
            if (pend_reg) out_data_reg <= ram_q;
         end
      end else if (pend_reg) begin
         skid_valid_reg <= 1'b1;
         skid_data_reg  <= ram_q;
         skid_last_reg  <= pend_last_reg;
      end
   end

   capture_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk     (clk_adc),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_reg),
      .wr_data (sample),
      .rd_en   (issue),
      .rd_addr (rd_addr_reg),
      .rd_data (ram_q)
   );

   assign rd_data   = out_data_reg;
   assign rd_valid  = out_valid_reg;
   assign rd_last   = out_last_reg;
   assign busy      = (state_reg != IDLE);
   assign triggered = triggered_reg;

endmodule
